// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the nested-loop sequencing controller: state encoding and defaults.
package loop_ctrl_pkg;

  localparam int unsigned DefNumLoops = 3;
  localparam int unsigned DefCntW     = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StInit    = 3'd1,
    StStop    = 3'd2,
    StRunning = 3'd3,
    StFinish  = 3'd4
  } state_e;

endpackage

// File: rtl/loop_counter.sv
// Single loop-level index counter with clear-over-increment priority and last-value flag.
module loop_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] bound_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ov_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ov_o  = (cnt_q == bound_i - CNT_W'(1));

endmodule

// File: rtl/loop_nest_controller.sv
// Sequences NUM_LOOPS nested index counters over a FIFO-fed datapath, gated by empty and stall.
module loop_nest_controller
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LOOPS = DefNumLoops,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [NUM_LOOPS*CNT_W-1:0] bound_i,
  input  logic                       empty_i,
  input  logic                       stall_i,
  output logic [NUM_LOOPS*CNT_W-1:0] idx_o,
  output logic [NUM_LOOPS-1:0]       en_lvl_o,
  output logic [NUM_LOOPS-1:0]       clr_lvl_o,
  output logic                       clr_acc_o,
  output logic                       ctrl_en_o,
  output logic                       ld_o,
  output logic                       stall_hold_o,
  output logic                       busy_o,
  output logic                       done_o
);

  state_e state_q, state_d;

  logic [NUM_LOOPS-1:0][CNT_W-1:0] bnd_q, bnd_eff;
  logic [NUM_LOOPS-1:0]            ov;
  logic                            is_init, advance, last;
  logic                            busy_q, ctrl_en_q, done_q;

  assign is_init = (state_q == StInit);
  assign advance = (state_q == StRunning) & ~empty_i & ~stall_i;
  assign last    = advance & (&ov);

  for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_lvl
    logic [CNT_W-1:0] lvl_bound;
    logic [CNT_W-1:0] cnt;

    // Level i steps only when every inner level is at its last value.
    if (i == 0) begin : g_inner
      assign en_lvl_o[i] = advance;
    end else begin : g_outer
      assign en_lvl_o[i] = advance & (&ov[i-1:0]);
    end

    assign clr_lvl_o[i] = is_init | (en_lvl_o[i] & ov[i]);
    assign lvl_bound    = bound_i[i*CNT_W +: CNT_W];
    assign bnd_eff[i]   = (lvl_bound == '0) ? CNT_W'(1) : lvl_bound;

    loop_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr_lvl_o[i] | abort_i),
      .en_i   (en_lvl_o[i]),
      .bound_i(bnd_q[i]),
      .cnt_o  (cnt),
      .ov_o   (ov[i])
    );

    assign idx_o[i*CNT_W +: CNT_W] = cnt;
  end

  if (NUM_LOOPS == 1) begin : g_acc_single
    assign clr_acc_o = is_init | last;
  end else begin : g_acc_multi
    assign clr_acc_o = is_init | (advance & (&ov[NUM_LOOPS-1:1]));
  end

  assign ld_o         = last;
  assign stall_hold_o = stall_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i) state_d = StInit;
      StInit:    if (!start_i) state_d = StStop;
      StStop:    if (!empty_i && !stall_i) state_d = StRunning;
      StRunning: begin
        if (last) begin
          state_d = StFinish;
        end else if (empty_i || stall_i) begin
          state_d = StStop;
        end
      end
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort_i) state_d = StIdle;
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bnd_q     <= '0;
      busy_q    <= 1'b0;
      ctrl_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (is_init) bnd_q <= bnd_eff;
      busy_q    <= (state_d != StIdle);
      ctrl_en_q <= (state_d == StStop) || (state_d == StRunning);
      done_q    <= (state_d == StFinish);
    end
  end

  assign busy_o    = busy_q;
  assign ctrl_en_o = ctrl_en_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_loop_nest_controller.sv
// Scoreboard bench for loop_nest_controller: expected step records queued, popped on each step strobe.
module tb_loop_nest_controller;

  localparam int N = 3;
  localparam int W = 8;

  typedef struct packed {
    logic [N*W-1:0] idx;
    logic [N-1:0]   en;
    logic [N-1:0]   clr;
    logic           ld;
    logic           acc;
  } step_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [N*W-1:0] bound = '0;
  logic           empty = 1'b0;
  logic           stall = 1'b0;
  logic [N*W-1:0] idx;
  logic [N-1:0]   en_lvl, clr_lvl;
  logic           clr_acc, ctrl_en, ld, stall_hold, busy, done;

  int    n_chk = 0;
  int    n_fail = 0;
  int    steps_seen = 0;
  int    done_cnt = 0;
  logic  prev_ld = 1'b0;
  step_t exp_q[$];

  loop_nest_controller #(
    .NUM_LOOPS(N),
    .CNT_W    (W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .bound_i     (bound),
    .empty_i     (empty),
    .stall_i     (stall),
    .idx_o       (idx),
    .en_lvl_o    (en_lvl),
    .clr_lvl_o   (clr_lvl),
    .clr_acc_o   (clr_acc),
    .ctrl_en_o   (ctrl_en),
    .ld_o        (ld),
    .stall_hold_o(stall_hold),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected per-step record for an outer-to-inner nest of trip counts (0 counts as 1).
  task automatic push_run(input int b2, input int b1, input int b0);
    int e0, e1, e2;
    step_t s;
    logic o0, o1, o2;
    e0 = (b0 == 0) ? 1 : b0;
    e1 = (b1 == 0) ? 1 : b1;
    e2 = (b2 == 0) ? 1 : b2;
    for (int i2 = 0; i2 < e2; i2++)
      for (int i1 = 0; i1 < e1; i1++)
        for (int i0 = 0; i0 < e0; i0++) begin
          o0 = (i0 == e0 - 1);
          o1 = (i1 == e1 - 1);
          o2 = (i2 == e2 - 1);
          s.idx = {W'(i2), W'(i1), W'(i0)};
          s.en  = {o0 & o1, o0, 1'b1};
          s.clr = {o0 & o1 & o2, o0 & o1, o0};
          s.ld  = o0 & o1 & o2;
          s.acc = o1 & o2;
          exp_q.push_back(s);
        end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (en_lvl[0]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", {idx, en_lvl, clr_lvl, ld, clr_acc}, 64'h0);
        end else begin
          check("step", {idx, en_lvl, clr_lvl, ld, clr_acc}, exp_q.pop_front());
        end
        steps_seen++;
      end
      if (empty || stall) check("quiet_when_blocked", {en_lvl, ld}, '0);
      if (prev_ld || done) check("done_after_ld", done, prev_ld);
      prev_ld = ld;
      if (done) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    cyc(n);
    start = 1'b0;
  endtask

  task automatic wait_steps(input int n);
    int c = 0;
    while (steps_seen < n && c < 500) begin
      cyc(1);
      c++;
    end
    check("wait_steps", 64'(steps_seen >= n), 64'd1);
  endtask

  task automatic wait_done(input int prev);
    int c = 0;
    while (done_cnt == prev && c < 500) begin
      cyc(1);
      c++;
    end
    check("wait_done", 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic full_run(input int b2, input int b1, input int b0, input int hold);
    int d0;
    d0 = done_cnt;
    bound = {W'(b2), W'(b1), W'(b0)};
    push_run(b2, b1, b0);
    pulse_start(hold);
    wait_done(d0);
    check("idle_after_done", {busy, ctrl_en, idx}, '0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base, d0;
    logic [N*W-1:0] held;

    #2;
    check("reset_outputs", {idx, en_lvl, clr_lvl, clr_acc, ctrl_en, ld, busy, done}, '0);
    #5 rst = 1'b0;
    cyc(2);
    check("idle_outputs", {idx, en_lvl, clr_lvl, clr_acc, ctrl_en, ld, busy, done}, '0);

    // Plain 2x3x4 nest, 24 steps.
    full_run(2, 3, 4, 1);

    // Empty for 5 cycles mid-run.
    base = steps_seen;
    bound = {8'd2, 8'd3, 8'd4};
    push_run(2, 3, 4);
    pulse_start(1);
    wait_steps(base + 10);
    empty = 1'b1;
    held = idx;
    check("held_idx_value", idx, {8'd0, 8'd2, 8'd2});
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("idx_hold_empty", idx, held);
    end
    check("stop_status", {busy, ctrl_en}, 2'b11);
    empty = 1'b0;
    d0 = done_cnt;
    wait_done(d0);
    check("steps_total_2", 64'(steps_seen - base), 64'd24);
    check("queue_drained_2", 64'(exp_q.size()), 64'd0);

    // Empty and stall both high on the final step.
    base = steps_seen;
    push_run(2, 3, 4);
    pulse_start(1);
    wait_steps(base + 23);
    empty = 1'b1;
    stall = 1'b1;
    check("last_idx", idx, {8'd1, 8'd2, 8'd3});
    check("stall_hold", stall_hold, 1'b1);
    d0 = done_cnt;
    cyc(4);
    stall = 1'b0;
    cyc(2);
    check("no_finish_while_blocked", {64'(done_cnt), 62'd0, busy, ctrl_en}, {64'(d0), 62'd0, 2'b11});
    empty = 1'b0;
    wait_done(d0);
    check("queue_drained_3", 64'(exp_q.size()), 64'd0);

    // Zero bound treated as one; start held two cycles.
    base = steps_seen;
    full_run(0, 1, 3, 2);
    check("steps_total_4", 64'(steps_seen - base), 64'd3);

    // Abort on step 7.
    base = steps_seen;
    d0 = done_cnt;
    bound = {8'd2, 8'd3, 8'd4};
    push_run(2, 3, 4);
    pulse_start(1);
    wait_steps(base + 6);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_idle", {busy, ctrl_en, idx}, '0);
    exp_q.delete();
    cyc(10);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_steps", 64'(steps_seen - base), 64'd7);
    full_run(2, 3, 4, 1);

    // Asynchronous reset mid-run.
    base = steps_seen;
    d0 = done_cnt;
    push_run(2, 3, 4);
    pulse_start(1);
    wait_steps(base + 5);
    #3 rst = 1'b1;
    #1;
    check("async_reset", {idx, en_lvl, clr_lvl, clr_acc, ctrl_en, ld, busy, done}, '0);
    #2 rst = 1'b0;
    exp_q.delete();
    cyc(8);
    check("reset_no_done", {64'(done_cnt), 63'd0, busy}, {64'(d0), 64'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
